// File: rtl/nios_system_sixteen_bit_input.sv
// 16-bit Avalon-MM parallel input port: synchronized inputs, per-bit edge capture
// with write-1-to-clear, interrupt mask and a level interrupt.
module nios_system_sixteen_bit_input #(
  parameter int EDGE_TYPE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [15:0] in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  logic [15:0] s1_q, s2_q, prev_q;
  logic [15:0] irqmask_q, irqmask_d;
  logic [15:0] edgecap_q, edgecap_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] edge_det;
  logic [15:0] clr_mask;
  logic        wr_en, rd_en;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

  // Unsupported EDGE_TYPE values fall back to rising-edge detection.
  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = ~s2_q & prev_q;
      2:       edge_det = s2_q ^ prev_q;
      default: edge_det = s2_q & ~prev_q;
    endcase
  end

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && (address == 2'd2)) begin
      irqmask_d = writedata[15:0];
    end

    clr_mask = '0;
    if (wr_en && (address == 2'd3)) begin
      clr_mask = writedata[15:0];
    end
    // A new edge on the same cycle as a clear keeps the bit set.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;

    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        2'd0:    rdata_d = s2_q;
        2'd2:    rdata_d = irqmask_q;
        2'd3:    rdata_d = edgecap_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      rdata_q   <= '0;
    end else begin
      s1_q      <= in_port;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata = {16'h0000, rdata_q};
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_system_sixteen_bit_input.sv
// Bench for the 16-bit input port: three instances (rising, falling, any edge)
// share one bus; expectations are queued and consumed by monitor processes.
module tb_nios_system_sixteen_bit_input;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic [31:0] rdata [3];
  logic [2:0]  irq_w;
  logic        probe;

  always #5 clk = ~clk;

  nios_system_sixteen_bit_input #(.EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[0]), .irq(irq_w[0]));
  nios_system_sixteen_bit_input #(.EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[1]), .irq(irq_w[1]));
  nios_system_sixteen_bit_input #(.EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[2]), .irq(irq_w[2]));

  // kind 0 compares readdata, kind 1 compares irq
  typedef struct {
    int               kind;
    string            name;
    logic [2:0][31:0] exp;
  } item_t;

  item_t sb_q[$];
  item_t imm_q[$];
  event  imm_ev;
  int    n_chk  = 0;
  int    n_pass = 0;
  logic  mon_rd, mon_pb;
  item_t mon_it;

  function automatic void check_item(input item_t it);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] act;
      act = (it.kind == 1) ? {31'b0, irq_w[i]} : rdata[i];
      n_chk++;
      if (act === it.exp[i]) n_pass++;
      else $display("FAIL %s u%0d: actual %h required %h", it.name, i, act, it.exp[i]);
    end
  endfunction

  always @(posedge clk) begin
    mon_rd = chipselect & write_n;
    mon_pb = probe;
    #1;
    if (mon_rd || mon_pb) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: actual none-queued required queued expectation");
      end else begin
        mon_it = sb_q.pop_front();
        check_item(mon_it);
      end
    end
  end

  always begin
    @(imm_ev);
    while (imm_q.size() > 0) check_item(imm_q.pop_front());
  end

  function automatic item_t mk(input int kind, input string name,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2);
    item_t it;
    it.kind = kind; it.name = name;
    it.exp[0] = e0; it.exp[1] = e1; it.exp[2] = e2;
    return it;
  endfunction

  task automatic idle(input int n);
    chipselect = 1'b0; write_n = 1'b1; probe = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; probe = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input string name,
                    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    sb_q.push_back(mk(0, name, e0, e1, e2));
    chipselect = 1'b1; write_n = 1'b1; address = a; probe = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic prb(input int kind, input string name,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    sb_q.push_back(mk(kind, name, e0, e1, e2));
    chipselect = 1'b0; write_n = 1'b1; probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
  endtask

  initial begin
    #100000;
    n_chk++;
    $display("FAIL watchdog: actual timeout required completion");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = '0; in_port = '0; probe = 1'b0;
    repeat (3) @(negedge clk);
    imm_q.push_back(mk(1, "in_reset_irq", 0, 0, 0));
    imm_q.push_back(mk(0, "in_reset_rdata", 0, 0, 0));
    -> imm_ev;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd3, "reset_ec", 0, 0, 0);
    rd(2'd2, "reset_mask", 0, 0, 0);
    rd(2'd0, "reset_data", 0, 0, 0);
    prb(1, "reset_irq", 0, 0, 0);

    // rising edge on bit 0, latency of capture and irq
    wr(2'd2, 32'h1);
    rd(2'd2, "mask_load", 1, 1, 1);
    in_port = 16'h0001;
    idle(1);
    prb(1, "irq_after_k1", 0, 0, 0);
    prb(1, "irq_after_k2", 1, 0, 1);
    rd(2'd3, "ec_rise_b0", 1, 0, 1);
    rd(2'd0, "data_b0", 1, 1, 1);

    // write-1-to-clear, then clear coincident with a new edge
    wr(2'd3, 32'h1);
    prb(1, "irq_cleared", 0, 0, 0);
    rd(2'd3, "ec_cleared", 0, 0, 0);
    in_port = 16'h0000;
    idle(4);
    prb(1, "irq_fall_b0", 0, 1, 1);
    wr(2'd3, 32'h1);
    idle(1);
    in_port = 16'h0001;
    idle(2);
    wr(2'd3, 32'h1);
    rd(2'd3, "edge_beats_clear", 1, 0, 1);
    wr(2'd3, 32'hFFFF);
    rd(2'd3, "ec_all_cleared", 0, 0, 0);

    // masked capture on bit 15, then unmask
    wr(2'd2, 32'h0);
    in_port = 16'h8001;
    idle(3);
    prb(1, "irq_masked_off", 0, 0, 0);
    rd(2'd3, "ec_b15", 32'h8000, 0, 32'h8000);
    wr(2'd2, 32'h8000);
    prb(1, "irq_unmasked", 1, 0, 1);
    wr(2'd3, 32'hFFFF);

    // edge-type selection
    in_port = 16'hFFFF;
    idle(3);
    wr(2'd3, 32'hFFFF);
    in_port = 16'h00F0;
    idle(3);
    rd(2'd3, "ffff_to_00f0", 0, 32'hFF0F, 32'hFF0F);
    wr(2'd3, 32'hFFFF);
    in_port = 16'h0000;
    idle(3);
    wr(2'd3, 32'hFFFF);
    in_port = 16'h00F0;
    idle(3);
    rd(2'd3, "0000_to_00f0", 32'h00F0, 0, 32'h00F0);
    rd(2'd3, "read_no_clear", 32'h00F0, 0, 32'h00F0);

    // data register, reserved address, ignored writes
    wr(2'd3, 32'hFFFF);
    in_port = 16'hA5A5;
    idle(3);
    rd(2'd0, "data_a5a5", 32'hA5A5, 32'hA5A5, 32'hA5A5);
    rd(2'd1, "rsvd_read", 0, 0, 0);
    wr(2'd0, 32'h1234);
    wr(2'd1, 32'h1234);
    rd(2'd0, "data_ro", 32'hA5A5, 32'hA5A5, 32'hA5A5);
    rd(2'd1, "rsvd_after_wr", 0, 0, 0);
    wr(2'd2, 32'h1234_8000);
    rd(2'd2, "mask_hi_ignored", 32'h8000, 32'h8000, 32'h8000);
    rd(2'd3, "ec_a5a5", 32'hA505, 32'h0050, 32'hA555);
    wr(2'd2, 32'h8000);
    prb(0, "rdata_hold", 32'hA505, 32'h0050, 32'hA555);

    // asynchronous reset mid-cycle
    wr(2'd3, 32'hFFFF);
    wr(2'd2, 32'h00FF);
    in_port = 16'h0000;
    idle(3);
    wr(2'd3, 32'hFFFF);
    in_port = 16'h00FF;
    idle(3);
    rd(2'd3, "ec_00ff", 32'h00FF, 0, 32'h00FF);
    prb(1, "irq_00ff", 1, 0, 1);
    #2;
    imm_q.push_back(mk(1, "async_rst_irq", 0, 0, 0));
    imm_q.push_back(mk(0, "async_rst_rdata", 0, 0, 0));
    reset_n = 1'b0;
    #1;
    -> imm_ev;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd3, "rel_e1", 0, 0, 0);
    rd(2'd3, "rel_e2", 0, 0, 0);
    rd(2'd3, "rel_e3", 0, 0, 0);
    rd(2'd3, "rel_e4", 32'h00FF, 0, 32'h00FF);
    rd(2'd2, "rel_mask", 0, 0, 0);
    prb(1, "rel_irq", 0, 0, 0);
    idle(3);

    n_chk++;
    if (sb_q.size() == 0 && imm_q.size() == 0) n_pass++;
    else $display("FAIL leftover_expectations: actual %0d required 0", sb_q.size() + imm_q.size());
    summary();
    $finish;
  end

endmodule
